// File: rtl/async_sram_ctrl.sv
// Host-side controller for an external asynchronous SRAM: one host word is
// assembled from BEATS sequential byte-lane accesses with programmable timing.
`timescale 1ns/1ps
module async_sram_ctrl #(
    parameter int SRAM_ADDR_W = 19,
    parameter int SRAM_DATA_W = 8,
    parameter int BEATS       = 4,
    parameter int RD_WAIT     = 2,
    parameter int WR_PULSE    = 2,
    parameter int TURN        = 1,
    localparam int HADDR_W    = SRAM_ADDR_W - $clog2(BEATS),
    localparam int HDATA_W    = BEATS * SRAM_DATA_W
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic                   req_we,
    input  logic [HADDR_W-1:0]     req_addr,
    input  logic [HDATA_W-1:0]     req_wdata,
    input  logic [BEATS-1:0]       req_mask,
    output logic                   rsp_valid,
    output logic [HDATA_W-1:0]     rsp_data,
    output logic [SRAM_ADDR_W-1:0] sram_a,
    output logic [SRAM_DATA_W-1:0] sram_dq_out,
    output logic                   sram_dq_oe,
    input  logic [SRAM_DATA_W-1:0] sram_dq_in,
    output logic                   sram_ce_n,
    output logic                   sram_oe_n,
    output logic                   sram_we_n
);

    localparam int BW      = $clog2(BEATS);
    localparam int BEAT_W  = (BW > 0) ? BW : 1;
    localparam int CNT_MAX = (RD_WAIT > WR_PULSE) ? ((RD_WAIT > TURN) ? RD_WAIT : TURN)
                                                  : ((WR_PULSE > TURN) ? WR_PULSE : TURN);
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_RD, S_WS, S_WP, S_WH, S_DONE, S_TA
    } state_t;

    state_t                 state_q, state_d;
    logic [BEAT_W-1:0]      beat_q, beat_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [HADDR_W-1:0]     addr_q, addr_d;
    logic [HDATA_W-1:0]     wdata_q, wdata_d;
    logic [BEATS-1:0]       mask_q, mask_d;
    logic [HDATA_W-1:0]     rsp_data_q, rsp_data_d;
    logic                   rsp_valid_q, rsp_valid_d;
    logic                   ready_q, ready_d;
    logic [SRAM_ADDR_W-1:0] a_q, a_d;
    logic [SRAM_DATA_W-1:0] dq_out_q, dq_out_d;
    logic                   dq_oe_q, dq_oe_d;
    logic                   ce_n_q, ce_n_d;
    logic                   oe_n_q, oe_n_d;
    logic                   we_n_q, we_n_d;
    logic [BEAT_W:0]        nb;
    logic                   is_rd, is_wr;

    // Lowest enabled beat at or above start; MSB flags that one was found.
    function automatic logic [BEAT_W:0] find_beat(input logic [BEATS-1:0] mask,
                                                  input int unsigned start);
        logic [BEAT_W:0] r;
        r = '0;
        for (int unsigned b = 0; b < BEATS; b++) begin
            if (!r[BEAT_W] && b >= start && mask[b]) r = {1'b1, BEAT_W'(b)};
        end
        return r;
    endfunction

    always_comb begin
        state_d    = state_q;
        beat_d     = beat_q;
        cnt_d      = cnt_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        mask_d     = mask_q;
        rsp_data_d = rsp_data_q;
        nb         = '0;
        case (state_q)
            S_IDLE: begin
                if (req_valid && ready_q) begin
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    mask_d  = req_mask;
                    cnt_d   = '0;
                    beat_d  = '0;
                    if (!req_we) begin
                        state_d = S_RD;
                    end else begin
                        nb = find_beat(req_mask, 0);
                        if (nb[BEAT_W]) begin
                            state_d = S_WS;
                            beat_d  = nb[BEAT_W-1:0];
                        end else begin
                            state_d = S_DONE;
                        end
                    end
                end
            end
            S_RD: begin
                if (cnt_q == CNT_W'(RD_WAIT - 1)) begin
                    rsp_data_d[int'(beat_q)*SRAM_DATA_W +: SRAM_DATA_W] = sram_dq_in;
                    cnt_d = '0;
                    if (beat_q == BEAT_W'(BEATS - 1)) state_d = S_DONE;
                    else                              beat_d  = beat_q + 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_WS: begin
                state_d = S_WP;
                cnt_d   = '0;
            end
            S_WP: begin
                if (cnt_q == CNT_W'(WR_PULSE - 1)) state_d = S_WH;
                else                               cnt_d   = cnt_q + 1'b1;
            end
            S_WH: begin
                nb = find_beat(mask_q, 32'(beat_q) + 1);
                if (nb[BEAT_W]) begin
                    state_d = S_WS;
                    beat_d  = nb[BEAT_W-1:0];
                end else begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                cnt_d   = '0;
                state_d = (TURN > 0) ? S_TA : S_IDLE;
            end
            S_TA: begin
                if (cnt_q == CNT_W'(TURN - 1)) state_d = S_IDLE;
                else                           cnt_d   = cnt_q + 1'b1;
            end
            default: state_d = S_IDLE;
        endcase

        // Pin outputs are decoded from the next state so the registers line up with it.
        is_rd       = (state_d == S_RD);
        is_wr       = (state_d == S_WS) || (state_d == S_WP) || (state_d == S_WH);
        a_d         = (is_rd || is_wr) ? ((SRAM_ADDR_W'(addr_d) << BW) | SRAM_ADDR_W'(beat_d)) : a_q;
        dq_out_d    = is_wr ? wdata_d[int'(beat_d)*SRAM_DATA_W +: SRAM_DATA_W] : dq_out_q;
        dq_oe_d     = is_wr;
        ce_n_d      = !(is_rd || is_wr);
        oe_n_d      = !is_rd;
        we_n_d      = (state_d != S_WP);
        rsp_valid_d = (state_d == S_DONE);
        ready_d     = (state_d == S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            beat_q      <= '0;
            cnt_q       <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            mask_q      <= '0;
            rsp_data_q  <= '0;
            rsp_valid_q <= 1'b0;
            ready_q     <= 1'b0;
            a_q         <= '0;
            dq_out_q    <= '0;
            dq_oe_q     <= 1'b0;
            ce_n_q      <= 1'b1;
            oe_n_q      <= 1'b1;
            we_n_q      <= 1'b1;
        end else begin
            state_q     <= state_d;
            beat_q      <= beat_d;
            cnt_q       <= cnt_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            mask_q      <= mask_d;
            rsp_data_q  <= rsp_data_d;
            rsp_valid_q <= rsp_valid_d;
            ready_q     <= ready_d;
            a_q         <= a_d;
            dq_out_q    <= dq_out_d;
            dq_oe_q     <= dq_oe_d;
            ce_n_q      <= ce_n_d;
            oe_n_q      <= oe_n_d;
            we_n_q      <= we_n_d;
        end
    end

    assign req_ready   = ready_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_data    = rsp_data_q;
    assign sram_a      = a_q;
    assign sram_dq_out = dq_out_q;
    assign sram_dq_oe  = dq_oe_q;
    assign sram_ce_n   = ce_n_q;
    assign sram_oe_n   = oe_n_q;
    assign sram_we_n   = we_n_q;

endmodule

// File: tb/tb_async_sram_ctrl.sv
// Directed bench for async_sram_ctrl with a behavioural asynchronous SRAM and
// a strobe monitor running across all tests.
`timescale 1ns/1ps
module tb_async_sram_ctrl;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        req_valid, req_ready, req_we;
    logic [16:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_mask;
    logic        rsp_valid;
    logic [31:0] rsp_data;
    logic [18:0] sram_a;
    logic [7:0]  sram_dq_out, sram_dq_in;
    logic        sram_dq_oe, sram_ce_n, sram_oe_n, sram_we_n;

    int n_checks = 0;
    int n_fail   = 0;
    int rsp_seen = 0;
    int we_pulses = 0;

    always #5 clk = ~clk;

    async_sram_ctrl dut (
        .clk(clk), .reset_n(reset_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_mask(req_mask),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data),
        .sram_a(sram_a), .sram_dq_out(sram_dq_out), .sram_dq_oe(sram_dq_oe),
        .sram_dq_in(sram_dq_in), .sram_ce_n(sram_ce_n), .sram_oe_n(sram_oe_n),
        .sram_we_n(sram_we_n)
    );

    // Asynchronous SRAM: latches on WE_n rising edge, reads combinationally.
    logic [7:0] mem [0:(1<<19)-1];
    always @(posedge sram_we_n) if (sram_ce_n === 1'b0) mem[sram_a] <= sram_dq_out;
    assign sram_dq_in = (!sram_ce_n && !sram_oe_n) ? mem[sram_a] : 8'h00;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    logic [18:0] a_p;
    logic [7:0]  dq_p;
    logic        oe_p = 1'b0, wen_p = 1'b1;
    int          we_low = 0;

    always @(negedge clk) begin
        if (reset_n === 1'b1) begin
            if (rsp_valid) rsp_seen++;
            if (!sram_oe_n || sram_dq_oe) check("oe_dq_excl", !sram_oe_n && sram_dq_oe, 0);
            if (!sram_we_n) check("we_needs_dq_oe", sram_dq_oe, 1);
            if (sram_dq_oe && oe_p && (!sram_we_n || !wen_p)) begin
                check("a_stable", sram_a, a_p);
                check("dq_stable", sram_dq_out, dq_p);
            end
            if (!sram_we_n) begin
                we_low++;
            end else if (we_low != 0) begin
                check("we_width", we_low, 2);
                we_pulses++;
                we_low = 0;
            end
            a_p   = sram_a;
            dq_p  = sram_dq_out;
            oe_p  = sram_dq_oe;
            wen_p = sram_we_n;
        end else begin
            we_low = 0;
            oe_p   = 1'b0;
            wen_p  = 1'b1;
        end
    end

    // Entered at a negedge; returns at the negedge where rsp_valid is seen.
    task automatic xact(input logic we, input logic [16:0] addr, input logic [31:0] wd,
                        input logic [3:0] mask, input bit hold,
                        output int wait_cyc, output int lat);
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_wdata = wd;
        req_mask  = mask;
        wait_cyc  = 0;
        while (!req_ready && wait_cyc < 100) begin
            @(negedge clk);
            wait_cyc++;
        end
        @(negedge clk);
        if (!hold) req_valid = 1'b0;
        lat = 1;
        while (!rsp_valid && lat < 100) begin
            @(negedge clk);
            lat++;
        end
    endtask

    int w, lat, p, r0;

    initial begin
        reset_n   = 1'b0;
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        req_mask  = '0;

        // T1 reset
        repeat (3) @(negedge clk);
        check("rst_ce_n", sram_ce_n, 1);
        check("rst_oe_n", sram_oe_n, 1);
        check("rst_we_n", sram_we_n, 1);
        check("rst_dq_oe", sram_dq_oe, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_ready", req_ready, 0);
        check("rst_a", sram_a, 0);
        check("rst_dq_out", sram_dq_out, 0);
        check("rst_rsp_data", rsp_data, 0);
        reset_n = 1'b1;
        @(negedge clk);
        check("ready_after_rst", req_ready, 1);

        // T2 full write then read
        xact(1'b1, 17'h10, 32'hDEADBEEF, 4'hF, 1'b0, w, lat);
        check("wr_full_lat", lat, 17);
        check("mem_40_43", {mem[19'h43], mem[19'h42], mem[19'h41], mem[19'h40]}, 32'hDEADBEEF);
        @(negedge clk);
        check("rsp_one_cycle", rsp_valid, 0);
        xact(1'b0, 17'h10, 32'h0, 4'h0, 1'b0, w, lat);
        check("rd_lat", lat, 9);
        check("rd_data", rsp_data, 32'hDEADBEEF);

        // T3 partial and empty writes
        xact(1'b1, 17'h10, 32'h00550000, 4'b0100, 1'b0, w, lat);
        check("wr_part_lat", lat, 5);
        check("mem_part", {mem[19'h43], mem[19'h42], mem[19'h41], mem[19'h40]}, 32'hDE55BEEF);
        xact(1'b0, 17'h10, 32'h0, 4'h0, 1'b0, w, lat);
        check("rd_part_lat", lat, 9);
        check("rd_part_data", rsp_data, 32'hDE55BEEF);
        p = we_pulses;
        xact(1'b1, 17'h10, 32'hFFFFFFFF, 4'h0, 1'b0, w, lat);
        check("wr_mask0_lat", lat, 1);
        @(negedge clk);
        check("mask0_no_pulse", we_pulses, p);
        check("mask0_mem", {mem[19'h43], mem[19'h42], mem[19'h41], mem[19'h40]}, 32'hDE55BEEF);

        // T5 back-to-back with req_valid held
        xact(1'b0, 17'h10, 32'h0, 4'h0, 1'b1, w, lat);
        check("b2b_rd1_lat", lat, 9);
        check("b2b_rd1_data", rsp_data, 32'hDE55BEEF);
        xact(1'b1, 17'h11, 32'h01020304, 4'hF, 1'b1, w, lat);
        check("b2b_gap1", w, 2);
        check("b2b_wr_lat", lat, 17);
        check("b2b_wr_keeps_data", rsp_data, 32'hDE55BEEF);
        xact(1'b0, 17'h11, 32'h0, 4'h0, 1'b0, w, lat);
        check("b2b_gap2", w, 2);
        check("b2b_rd2_lat", lat, 9);
        check("b2b_rd2_data", rsp_data, 32'h01020304);

        // T6 reset during beat 2 write pulse
        xact(1'b1, 17'h20, 32'h11223344, 4'hF, 1'b0, w, lat);
        check("pre_mem_80", {mem[19'h83], mem[19'h82], mem[19'h81], mem[19'h80]}, 32'h11223344);
        @(negedge clk);
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_addr  = 17'h20;
        req_wdata = 32'hAABBCCDD;
        req_mask  = 4'hF;
        w = 0;
        while (!req_ready && w < 100) begin
            @(negedge clk);
            w++;
        end
        @(negedge clk);
        req_valid = 1'b0;
        r0 = rsp_seen;
        repeat (9) @(negedge clk);
        check("t6_in_beat2_wp", {sram_we_n, sram_a}, {1'b0, 19'h82});
        reset_n = 1'b0;
        @(negedge clk);
        check("t6_ce_n", sram_ce_n, 1);
        check("t6_oe_n", sram_oe_n, 1);
        check("t6_we_n", sram_we_n, 1);
        check("t6_dq_oe", sram_dq_oe, 0);
        check("t6_ready", req_ready, 0);
        check("t6_rsp_valid", rsp_valid, 0);
        check("t6_a", sram_a, 0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        check("t6_ready_after", req_ready, 1);
        repeat (3) @(negedge clk);
        check("t6_no_rsp", rsp_seen, r0);
        check("t6_byte0", mem[19'h80], 8'hDD);
        check("t6_byte1", mem[19'h81], 8'hCC);
        check("t6_byte3", mem[19'h83], 8'h11);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
